// File: rtl/pipe_pkg.sv
// pipe_pkg
//   Shared types and constants for the result-forwarding pipeline.
//   - buf_rec_t : one pipeline buffer record {result, dst, wb, mem_read, mem_write}
//   - BUBBLE    : all-zero record, used for squashed or empty slots
//   - FLAG_C/Z/N: bit positions inside the 3-bit flag vector {C,Z,N}
//   - stall_state_t : RUN/HOLD states of the load-use stall FSM
//   PIPE_N / PIPE_RW are the record field widths. The top-level N/RW
//   parameters default to them and must stay equal to them.
package pipe_pkg;

    localparam int PIPE_N  = 16;
    localparam int PIPE_RW = 3;

    localparam int FLAG_C = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    typedef struct packed {
        logic [PIPE_N-1:0]  result;
        logic [PIPE_RW-1:0] dst;
        logic               wb;
        logic               mem_read;
        logic               mem_write;
    } buf_rec_t;

    localparam buf_rec_t BUBBLE = '0;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } stall_state_t;

endpackage

// File: rtl/result_forward_pipe_load_use_detect.sv
// load_use_detect
//   Detects a load in EX whose destination is read by the instruction in
//   decode, and raises a registered one-cycle stall for that pair.
//   Ports:
//     clk, rst                 : clock, synchronous active-high reset
//     ex_valid/ex_mem_read/ex_wb/ex_dst : EX-slot instruction description
//     id_src/id_dst, id_use_src/id_use_dst : decode operands and read enables
//     flush                    : EX slot is being squashed (suppresses stall)
//     stall                    : registered stall, high for exactly one cycle
module load_use_detect
    import pipe_pkg::*;
#(
    parameter int RW = PIPE_RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    input  logic          ex_mem_read,
    input  logic          ex_wb,
    input  logic [RW-1:0] ex_dst,
    input  logic [RW-1:0] id_src,
    input  logic [RW-1:0] id_dst,
    input  logic          id_use_src,
    input  logic          id_use_dst,
    input  logic          flush,
    output logic          stall
);

    stall_state_t state, state_nxt;
    logic         hz;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        hz = ex_valid & ex_mem_read & ex_wb &
             ((id_use_src & (id_src == ex_dst)) | (id_use_dst & (id_dst == ex_dst)));
        case (state)
            ST_RUN:  if (hz & ~flush) state_nxt = ST_HOLD;
            // The load has already moved to buf2, so HOLD never re-arms.
            ST_HOLD: state_nxt = ST_RUN;
            default: state_nxt = ST_RUN;
        endcase
    end

    assign stall = (state == ST_HOLD);

endmodule

// File: rtl/result_forward_pipe.sv
// result_forward_pipe
//   Two-deep result buffer (buf2, buf3) behind EX supplying forwarding
//   sources, a load-data latch, committed condition flags and an optional
//   load-use stall.
//   Optional feature: FWD_LOAD_USE_STALL_EN -- when defined, load_use_detect
//   generates a one-cycle stall on a load-use hazard; otherwise stall is 0
//   and software must separate loads from their consumers.
//   Ports:
//     clk, rst       : clock, synchronous active-high reset
//     ex_*           : EX-slot instruction (valid, result, dst, wb, load,
//                      store, flags, flag write enable)
//     id_*           : decode operand indices and read enables
//     flush          : squash the EX-slot instruction
//     mem_rdata      : data memory read data for the instruction in buf2
//     result_prev1/reg2_buf2/wb1 : buf2 forwarding source
//     result_prev2/reg2_buf3/wb2 : buf3 forwarding source
//     mem_read_load_case, memory_data_output_load_case : buf3 load info
//     ccr            : committed flags {C,Z,N}
//     stall          : freeze fetch/decode, bubble EX
module result_forward_pipe
    import pipe_pkg::*;
#(
    parameter int N  = PIPE_N,
    parameter int RW = PIPE_RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    input  logic [N-1:0]  ex_result,
    input  logic [RW-1:0] ex_dst,
    input  logic          ex_wb,
    input  logic          ex_mem_read,
    input  logic          ex_mem_write,
    input  logic [2:0]    ex_flags,
    input  logic          ex_flags_we,
    input  logic [RW-1:0] id_src,
    input  logic [RW-1:0] id_dst,
    input  logic          id_use_src,
    input  logic          id_use_dst,
    input  logic          flush,
    input  logic [N-1:0]  mem_rdata,
    output logic [N-1:0]  result_prev1,
    output logic [RW-1:0] reg2_buf2,
    output logic          wb1,
    output logic [N-1:0]  result_prev2,
    output logic [RW-1:0] reg2_buf3,
    output logic          wb2,
    output logic          mem_read_load_case,
    output logic [N-1:0]  memory_data_output_load_case,
    output logic [2:0]    ccr,
    output logic          stall
);

    buf_rec_t     buf2, buf3;
    logic [N-1:0] ld_data;
    logic         capture;

`ifdef FWD_LOAD_USE_STALL_EN
    load_use_detect #(.RW(RW)) u_lud (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_mem_read(ex_mem_read),
        .ex_wb      (ex_wb),
        .ex_dst     (ex_dst),
        .id_src     (id_src),
        .id_dst     (id_dst),
        .id_use_src (id_use_src),
        .id_use_dst (id_use_dst),
        .flush      (flush),
        .stall      (stall)
    );
`else
    assign stall = 1'b0;
    // Decode operands only matter to the hazard detector.
    logic unused_id;
    assign unused_id = ^{id_src, id_dst, id_use_src, id_use_dst};
`endif

    // A stall cycle turns the EX slot into a bubble, as does a flush.
    assign capture = ex_valid & ~flush & ~stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            buf2    <= BUBBLE;
            buf3    <= BUBBLE;
            ld_data <= '0;
            ccr     <= 3'b000;
        end else begin
            buf2 <= capture ? '{result:    ex_result,
                                dst:       ex_dst,
                                wb:        ex_wb,
                                mem_read:  ex_mem_read,
                                mem_write: ex_mem_write} : BUBBLE;
            buf3    <= buf2;
            ld_data <= mem_rdata;
            if (capture & ex_flags_we) begin
                ccr[FLAG_C] <= ex_flags[FLAG_C];
                ccr[FLAG_Z] <= ex_flags[FLAG_Z];
                ccr[FLAG_N] <= ex_flags[FLAG_N];
            end
        end
    end

    // Store flag has no consumer past buf2.
    logic unused_mem_write;
    assign unused_mem_write = buf3.mem_write;

    assign result_prev1                 = buf2.result;
    assign reg2_buf2                    = buf2.dst;
    // A load's buf2 result is its address, never forwardable data.
    assign wb1                          = buf2.wb & ~buf2.mem_read;
    assign result_prev2                 = buf3.result;
    assign reg2_buf3                    = buf3.dst;
    assign wb2                          = buf3.wb;
    assign mem_read_load_case           = buf3.mem_read;
    assign memory_data_output_load_case = ld_data;

endmodule
